// File: rtl/mips_hazard_scoreboard_pkg.sv
// Shared pipeline definitions for the MIPS hazard scoreboard: register address
// width, forward select encoding and the scoreboard entry layout.
package mips_pipe_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int FWD_RF         = 0;
  localparam int FWD_ENTRY_BASE = 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    logic      regwrite;
    logic      isload;
    reg_addr_t dest;
  } sb_entry_t;

  localparam int SB_ENTRY_W = $bits(sb_entry_t);

endpackage

// File: rtl/mips_hazard_scoreboard_if.sv
// Decode-stage interface of the hazard scoreboard: D instruction info in,
// stall/bubble/forward controls out. StallCount exists only with MIPS_HAZARD_STALL_COUNT_EN.
interface mips_hazard_scoreboard_if
  import mips_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
);

  logic             ValidD;
  reg_addr_t        RsD;
  reg_addr_t        RtD;
  logic             UseRsD;
  logic             UseRtD;
  logic             RegWriteD;
  logic             MemReadD;
  reg_addr_t        WriteRegD;
  logic             FlushD;
  logic             HoldIn;
  logic             StallF;
  logic             StallD;
  logic             BubbleE;
  logic [FWD_W-1:0] ForwardAD;
  logic [FWD_W-1:0] ForwardBD;
`ifdef MIPS_HAZARD_STALL_COUNT_EN
  logic [31:0]      StallCount;
`endif

  modport master (
    output ValidD, RsD, RtD, UseRsD, UseRtD, RegWriteD, MemReadD, WriteRegD,
           FlushD, HoldIn,
    input  StallF, StallD, BubbleE, ForwardAD, ForwardBD
`ifdef MIPS_HAZARD_STALL_COUNT_EN
    , input StallCount
`endif
  );

  modport slave (
    input  ValidD, RsD, RtD, UseRsD, UseRtD, RegWriteD, MemReadD, WriteRegD,
           FlushD, HoldIn,
    output StallF, StallD, BubbleE, ForwardAD, ForwardBD
`ifdef MIPS_HAZARD_STALL_COUNT_EN
    , output StallCount
`endif
  );

endinterface

// File: rtl/mips_hazard_scoreboard_fwd_select.sv
// Priority search over the scoreboard for one source operand: youngest matching
// entry wins; a load match that is not yet forwardable raises a hazard instead.
module mips_fwd_select
  import mips_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 2,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input  sb_entry_t [NUM_STAGES-1:0] sb,
  input  reg_addr_t                  src,
  input  logic                       use_src,
  output logic [FWD_W-1:0]           fwd,
  output logic                       hazard
);

  // Walk oldest to youngest so the lowest matching index overrides the rest.
  always_comb begin
    fwd    = FWD_W'(FWD_RF);
    hazard = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (use_src && sb[i].valid && sb[i].regwrite &&
          (sb[i].dest == src) && (sb[i].dest != '0)) begin
        if (!sb[i].isload || (i >= LOAD_LAT)) begin
          fwd    = FWD_W'(i + FWD_ENTRY_BASE);
          hazard = 1'b0;
        end else begin
          fwd    = FWD_W'(FWD_RF);
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// Hazard/forwarding unit: shifts D-stage destinations through a NUM_STAGES-deep
// scoreboard and drives forwarding selects, stalls and E bubbles. Optional
// stall counter enabled by MIPS_HAZARD_STALL_COUNT_EN.
module mips_hazard_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 2,
  parameter int FWD_W      = $clog2(NUM_STAGES + 1)
) (
  input logic                     Clk,
  input logic                     Reset,
  mips_hazard_scoreboard_if.slave bus
);

  sb_entry_t [NUM_STAGES-1:0] sb;
  sb_entry_t                  entry_new;
  logic                       haz_a;
  logic                       haz_b;
  logic                       hazard;

  mips_fwd_select #(
    .NUM_STAGES (NUM_STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .FWD_W      (FWD_W)
  ) u_fwd_a (
    .sb      (sb),
    .src     (bus.RsD),
    .use_src (bus.UseRsD),
    .fwd     (bus.ForwardAD),
    .hazard  (haz_a)
  );

  mips_fwd_select #(
    .NUM_STAGES (NUM_STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .FWD_W      (FWD_W)
  ) u_fwd_b (
    .sb      (sb),
    .src     (bus.RtD),
    .use_src (bus.UseRtD),
    .fwd     (bus.ForwardBD),
    .hazard  (haz_b)
  );

  // A flushed or empty D slot can never stall the front end.
  assign hazard      = (haz_a || haz_b) && bus.ValidD && !bus.FlushD;
  assign bus.StallF  = hazard || bus.HoldIn;
  assign bus.StallD  = hazard || bus.HoldIn;
  assign bus.BubbleE = hazard && !bus.HoldIn;

  always_comb begin
    entry_new.valid    = bus.ValidD && !hazard && !bus.FlushD;
    entry_new.regwrite = bus.RegWriteD;
    entry_new.isload   = bus.MemReadD;
    entry_new.dest     = bus.WriteRegD;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sb <= '0;
    end else if (!bus.HoldIn) begin
      for (int i = NUM_STAGES - 1; i > 0; i--) begin
        sb[i] <= sb[i-1];
      end
      sb[0] <= entry_new;
    end
  end

`ifdef MIPS_HAZARD_STALL_COUNT_EN
  logic [31:0] stall_count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      stall_count <= '0;
    end else if (hazard && !bus.HoldIn && (stall_count != 32'hFFFF_FFFF)) begin
      stall_count <= stall_count + 32'd1;
    end
  end

  assign bus.StallCount = stall_count;
`endif

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Directed bench for mips_hazard_scoreboard (NUM_STAGES = 3, LOAD_LAT = 2).
module tb_mips_hazard_scoreboard;
  import mips_pipe_pkg::*;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  mips_hazard_scoreboard_if #(.NUM_STAGES(3)) dif ();

  mips_hazard_scoreboard #(
    .NUM_STAGES (3),
    .LOAD_LAT   (2)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (dif.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic stall, input logic bubble,
                           input logic [1:0] fa, input logic [1:0] fb);
    check_eq({tag, ".StallF"},    32'(dif.StallF),    32'(stall));
    check_eq({tag, ".StallD"},    32'(dif.StallD),    32'(stall));
    check_eq({tag, ".BubbleE"},   32'(dif.BubbleE),   32'(bubble));
    check_eq({tag, ".ForwardAD"}, 32'(dif.ForwardAD), 32'(fa));
    check_eq({tag, ".ForwardBD"}, 32'(dif.ForwardBD), 32'(fb));
  endtask

  task automatic set_d(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic ur, input logic ut, input logic rw, input logic mr,
                       input logic [4:0] wr);
    dif.ValidD    = v;
    dif.RsD       = rs;
    dif.RtD       = rt;
    dif.UseRsD    = ur;
    dif.UseRtD    = ut;
    dif.RegWriteD = rw;
    dif.MemReadD  = mr;
    dif.WriteRegD = wr;
    #1;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    Reset      = 1'b1;
    dif.FlushD = 1'b0;
    dif.HoldIn = 1'b0;
    set_d(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    Reset = 1'b0;
    #1;
    check_out("reset", 0, 0, 0, 0);

    // ALU back-to-back: add r8 then sub reading r8 as Rs
    set_d(1, 9, 10, 1, 1, 1, 0, 8);
    tick();
    set_d(1, 8, 3, 1, 1, 0, 0, 0);
    check_out("alu_e", 0, 0, 1, 0);
    tick();
    check_out("alu_m", 0, 0, 2, 0);
    tick();
    check_out("alu_w", 0, 0, 3, 0);
    tick();
    check_out("alu_ret", 0, 0, 0, 0);
    drain();

    // Load-use: two stall cycles, then forward from W
    set_d(1, 29, 0, 1, 0, 1, 1, 8);
    tick();
    set_d(1, 8, 8, 1, 1, 1, 0, 9);
    check_out("lu_c0", 1, 1, 0, 0);
    tick();
    check_out("lu_c1", 1, 1, 0, 0);
    tick();
    check_out("lu_fwd", 0, 0, 3, 3);
`ifdef MIPS_HAZARD_STALL_COUNT_EN
    check_eq("stall_count", dif.StallCount, 32'd2);
`endif
    drain();

    // Register 0 never matches
    set_d(1, 29, 0, 1, 0, 1, 1, 0);
    tick();
    set_d(1, 0, 0, 1, 1, 1, 0, 9);
    check_out("r0", 0, 0, 0, 0);
    drain();

    // Priority: lw r8 at E hides older add r8; Rt not used so no B match
    set_d(1, 1, 2, 1, 1, 1, 0, 8);
    tick();
    set_d(1, 29, 0, 1, 0, 1, 1, 8);
    tick();
    set_d(1, 8, 8, 1, 0, 1, 0, 9);
    check_out("prio", 1, 1, 0, 0);
    drain();

    // Hold during load-use stall
    set_d(1, 29, 0, 1, 0, 1, 1, 8);
    tick();
    set_d(1, 8, 4, 1, 1, 1, 0, 9);
    check_out("hold_pre", 1, 1, 0, 0);
    tick();
    dif.HoldIn = 1'b1;
    #1;
    check_out("hold_h0", 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("hold_hk", 1, 0, 0, 0);
    end
    dif.HoldIn = 1'b0;
    #1;
    check_out("hold_rel", 1, 1, 0, 0);
    tick();
    check_out("hold_fwd", 0, 0, 3, 0);
    drain();

    // Flush wins over hazard; a bubble, not the D instruction, enters E
    set_d(1, 29, 0, 1, 0, 1, 1, 8);
    tick();
    set_d(1, 8, 8, 1, 1, 1, 0, 8);
    dif.FlushD = 1'b1;
    #1;
    check_out("flush", 0, 0, 0, 0);
    tick();
    dif.FlushD = 1'b0;
    #1;
    check_out("flush_after", 1, 1, 0, 0);
    drain();

    // Reset mid-stall empties the scoreboard
    set_d(1, 29, 0, 1, 0, 1, 1, 8);
    tick();
    set_d(1, 8, 8, 1, 1, 1, 0, 9);
    check_out("rst_pre", 1, 1, 0, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    check_out("rst_mid", 0, 0, 0, 0);
`ifdef MIPS_HAZARD_STALL_COUNT_EN
    check_eq("stall_count_rst", dif.StallCount, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
